// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit: stage register indices and control in,
// stall/flush/forward controls, error flag and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             ResultSrcE0;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             StallE;
  logic             StallM;
  logic             StallW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic [1:0]       state_dbg;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, FlushD, FlushE, StallE, StallM, StallW,
    input  ForwardAE, ForwardBE, MemErr, StallCount, FlushCount, state_dbg
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, FlushD, FlushE, StallE, StallM, StallW,
    output ForwardAE, ForwardBE, MemErr, StallCount, FlushCount, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32I core: forwarding, load-use stall, branch flush,
// data-memory wait freeze with sticky timeout error, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_nx;
  logic             mem_err;
  logic             freeze;
  logic             lw_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // M-stage result is newer than W-stage, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Memory handshake: MemReqM marks an access in flight; it completes in the cycle
  // MemReadyM is high. Once waiting, only MemReadyM releases the wait, even if the
  // request drops.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    freeze      = 1'b0;
    case (state)
      RUN: begin
        freeze = hz.MemReqM && !hz.MemReadyM;
        if (freeze) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == TIMEOUT_V)
            state_nx = MEM_ERR;
          else
            wait_cnt_nx = wait_cnt + WC_W'(1);
        end
      end
      MEM_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state_nx == MEM_ERR)
        mem_err <= 1'b1;
    end
  end

  // A freeze holds EX, so a branch seen during it is flushed once the freeze lifts.
  assign hz.StallF = lw_stall | freeze;
  assign hz.StallD = lw_stall | freeze;
  assign hz.StallE = freeze;
  assign hz.StallM = freeze;
  assign hz.StallW = freeze;
  assign hz.FlushD = hz.PCSrcE & !freeze;
  assign hz.FlushE = (lw_stall | hz.PCSrcE) & !freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.StallF && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.FlushE && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.MemErr     = mem_err;
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
  assign hz.state_dbg  = state;

endmodule
